mux_nto1_scan: RTL
==================

// Module: mux_nto1_scan
// PURPOSE
//  Parametrised, registered N-to-1 multiplexer with manual and auto-scan modes.
//  Generalises the 16-to-1 single-bit mux to N_CH channels of WIDTH bits each.
//  Adds a registered output, a channel tag, a valid strobe and a masked round-robin scanner.
//  Sits between a bank of sampled sources and a single serial consumer (e.g. display or UART path).
// PARAMETERS
//  WIDTH  1   bits per channel
//  N_CH   16  number of channels, 2..256
//  DWELL  4   cycles spent on each channel in scan mode, >=1
//  SEL_W  $clog2(N_CH)  select width, derived and not overridden
// PORTS
//  clk      in   1           rising-edge clock
//  rst_n    in   1           asynchronous active-low reset
//  inp      in   N_CH*WIDTH  channel k occupies inp[k*WIDTH +: WIDTH]
//  sele     in   SEL_W       manual channel select
//  mode     in   1           0=manual, 1=scan
//  en       in   1           block enable
//  ch_mask  in   N_CH        scan mode: 1=channel included
//  outp     out  WIDTH       registered selected data
//  out_ch   out  SEL_W       channel index of outp
//  out_vld  out  1           outp/out_ch valid this cycle
//  wrap     out  1           one-cycle pulse when a scan pass restarts
// BEHAVIOUR
//  - Reset (async, rst_n=0): outp=0, out_ch=0, out_vld=0, wrap=0, ptr=0, dwell=0, state=IDLE.
//  - Priority: rst_n > en > mode. All outputs are registered, with latency 1 clk from inputs.
//  - FSM states: IDLE, MANUAL, SCAN. Every state moves on each edge:
//      en=0 -> IDLE; en=1 & mode=0 -> MANUAL; en=1 & mode=1 -> SCAN.
//  - IDLE: outp and out_ch hold their last values. out_vld=0, wrap=0.
//  - MANUAL: next outp = inp slice[sele], out_ch=sele, out_vld=1.
//      sele>=N_CH (non-power-of-2 N_CH): outp=0, out_ch=sele, out_vld=0.
//  - SCAN entry (from IDLE/MANUAL):
//      ptr = lowest set bit of ch_mask, dwell=0, wrap=0.
//      Entry does not update outp; the first scan output appears on the next edge.
//  - SCAN steady: each cycle, outp=inp[ptr], out_ch=ptr, out_vld=1, dwell++.
//      When dwell==DWELL-1: dwell=0 and ptr moves to the next set mask bit above ptr.
//      If there is none above ptr, ptr wraps to the lowest set bit.
//      wrap=1 on the first output cycle of the wrapped channel.
//      Single enabled channel: ptr stays put; wrap pulses every DWELL cycles.
//  - ch_mask is sampled at each advance. A channel masked mid-dwell finishes its dwell.
//  - ch_mask==0 in SCAN: ptr and dwell hold, out_vld=0, wrap=0, outp holds.
//      Scan resumes at the next set bit above ptr once the mask goes nonzero.
//  - Mode change mid-scan: switches next edge. Returning to SCAN re-enters from the lowest set bit.
//  - Reset mid-operation: immediate async clear. Outputs are zero while rst_n=0.
//  - Widths: ptr and dwell never exceed N_CH-1 and DWELL-1; there is no arithmetic overflow.
// TESTING
//  Bench params WIDTH=1, N_CH=16, DWELL=4 unless stated.
//  1 Manual: inp=16'h3f0a, en=1, mode=0; sele=0,1,2 on successive clks ->
//     outp=0,1,0 one clk later each, out_ch tracks sele, out_vld=1.
//  2 Scan, full mask: ch_mask=16'hffff, inp=16'hAAAA ->
//     out_ch=0 for 4 clks, then 1..15 for 4 clks each.
//     Then out_ch=0 with wrap=1 for exactly 1 clk; outp alternates 0/1 per channel.
//  3 Scan, sparse mask: ch_mask=16'h8011 -> out_ch sequence 0,4,15,0.
//     wrap is high only on the return to 0; a mask change to 16'h0010 mid-dwell on ch4 -> ch4 repeats.
//  4 Empty mask and en: ch_mask=0 in SCAN -> out_vld=0, outp held.
//     en=0 -> out_vld=0 next clk, outp held; en=1 resumes per FSM.
//  5 Async reset mid-scan: drop rst_n between edges -> all outputs 0 without a clk.
//     Release -> IDLE, then SCAN restarts at the lowest mask bit.
//  6 WIDTH=8, N_CH=5: inp={8'h55,8'h44,8'h33,8'h22,8'h11}, manual sele=4 -> outp=8'h55.
//     sele=6 -> outp=0, out_vld=0; scan visits channels 0..4 only.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 multiplexer with a manual select mode and a masked round-robin scan mode.
// Each output carries the channel index, a valid strobe, and a wrap pulse for each new scan pass.
module mux_nto1_scan #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N_CH  = 16,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*WIDTH-1:0]   inp,
  input  logic [SEL_W-1:0]        sele,
  input  logic                    mode,
  input  logic                    en,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [WIDTH-1:0]        outp,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_vld,
  output logic                    wrap
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             stall_q, stall_d;
  logic             first_wrap_q, first_wrap_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_vld_q, out_vld_d;
  logic             wrap_q, wrap_d;

  logic [SEL_W-1:0] lowest, next_up, adv_ptr;
  logic             found_lo, found_up, adv_wrap, mask_any, sel_ok;
  logic [WIDTH-1:0] scan_data, man_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      dwell_q      <= '0;
      stall_q      <= 1'b0;
      first_wrap_q <= 1'b0;
      outp_q       <= '0;
      out_ch_q     <= '0;
      out_vld_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dwell_q      <= dwell_d;
      stall_q      <= stall_d;
      first_wrap_q <= first_wrap_d;
      outp_q       <= outp_d;
      out_ch_q     <= out_ch_d;
      out_vld_q    <= out_vld_d;
      wrap_q       <= wrap_d;
    end
  end

  always_comb begin
    if (!en)       state_d = StIdle;
    else if (mode) state_d = StScan;
    else           state_d = StManual;
  end

  // Lowest set mask bit, and the first set bit strictly above the current pointer.
  always_comb begin
    lowest    = '0;
    next_up   = '0;
    found_lo  = 1'b0;
    found_up  = 1'b0;
    scan_data = '0;
    man_data  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_mask[i] && !found_lo) begin
        lowest   = SEL_W'(i);
        found_lo = 1'b1;
      end
      if (ch_mask[i] && !found_up && (i > 32'(ptr_q))) begin
        next_up  = SEL_W'(i);
        found_up = 1'b1;
      end
      if (32'(ptr_q) == i) scan_data = inp[i*WIDTH +: WIDTH];
      if (32'(sele) == i)  man_data  = inp[i*WIDTH +: WIDTH];
    end
  end

  assign adv_ptr  = found_up ? next_up : lowest;
  assign adv_wrap = !found_up;
  assign mask_any = |ch_mask;
  assign sel_ok   = (32'(sele) < N_CH);

  always_comb begin
    ptr_d        = ptr_q;
    dwell_d      = dwell_q;
    stall_d      = stall_q;
    first_wrap_d = first_wrap_q;
    outp_d       = outp_q;
    out_ch_d     = out_ch_q;
    out_vld_d    = 1'b0;
    wrap_d       = 1'b0;
    unique case (state_d)
      StIdle: ;
      StManual: begin
        outp_d    = sel_ok ? man_data : '0;
        out_ch_d  = sele;
        out_vld_d = sel_ok;
      end
      StScan: begin
        if (state_q != StScan) begin
          // Entry only loads the pointer; data follows on the next edge.
          ptr_d        = lowest;
          dwell_d      = '0;
          stall_d      = !mask_any;
          first_wrap_d = 1'b0;
        end else if (!mask_any) begin
          stall_d = 1'b1;
        end else if (stall_q) begin
          ptr_d        = adv_ptr;
          dwell_d      = '0;
          stall_d      = 1'b0;
          first_wrap_d = adv_wrap;
        end else begin
          outp_d       = scan_data;
          out_ch_d     = ptr_q;
          out_vld_d    = 1'b1;
          wrap_d       = first_wrap_q;
          first_wrap_d = 1'b0;
          if (dwell_q == DW_W'(DWELL - 1)) begin
            dwell_d      = '0;
            ptr_d        = adv_ptr;
            first_wrap_d = adv_wrap;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign outp    = outp_q;
  assign out_ch  = out_ch_q;
  assign out_vld = out_vld_q;
  assign wrap    = wrap_q;

endmodule
